// File: rtl/alu32_dispatch.sv
// Master-side sequencer for the 32-bit ALU: accepts one request at a time, tags it
// with a rotating non-zero key, waits for the matching key from the ALU and returns the result.
module alu32_dispatch #(
    parameter int TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [7:0]  req_op,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        rsp_err,
    output logic        alu_en,
    output logic        alu_clr,
    output logic [7:0]  alu_op,
    output logic [7:0]  alu_key,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    input  logic [31:0] alu_res,
    input  logic [7:0]  alu_key_ret
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [7:0]  key_cnt_q, key_cnt_d;
    logic [7:0]  timer_q, timer_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_data_q, rsp_data_d;
    logic        rsp_err_q, rsp_err_d;
    logic [7:0]  alu_op_q, alu_op_d;
    logic [7:0]  alu_key_q, alu_key_d;
    logic [31:0] alu_a_q, alu_a_d;
    logic [31:0] alu_b_q, alu_b_d;
    logic        tmo_clr_q, tmo_clr_d;

    logic accept;
    logic op_valid;
    logic match;

    assign accept   = req_valid && req_ready;
    assign op_valid = (req_op == 8'h01) || (req_op == 8'h02) || (req_op == 8'h03);
    assign match    = (alu_key_ret == alu_key_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            key_cnt_q   <= 8'h01;
            timer_q     <= 8'h00;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 32'h0;
            rsp_err_q   <= 1'b0;
            alu_op_q    <= 8'h00;
            alu_key_q   <= 8'h00;
            alu_a_q     <= 32'h0;
            alu_b_q     <= 32'h0;
            tmo_clr_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            key_cnt_q   <= key_cnt_d;
            timer_q     <= timer_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
            alu_op_q    <= alu_op_d;
            alu_key_q   <= alu_key_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            tmo_clr_q   <= tmo_clr_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        key_cnt_d   = key_cnt_q;
        timer_d     = timer_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;
        alu_op_d    = alu_op_q;
        alu_key_d   = alu_key_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        tmo_clr_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (op_valid) begin
                        state_d   = ISSUE;
                        alu_op_d  = req_op;
                        alu_a_d   = req_a;
                        alu_b_d   = req_b;
                        alu_key_d = key_cnt_q;
                        // 0x00 is what the ALU reports while busy, so it is skipped
                        key_cnt_d = (key_cnt_q == 8'hFF) ? 8'h01 : key_cnt_q + 8'h01;
                    end else begin
                        state_d     = DONE;
                        rsp_valid_d = 1'b1;
                        rsp_data_d  = 32'h0;
                        rsp_err_d   = 1'b1;
                    end
                end
            end
            ISSUE: begin
                state_d = WAIT;
                timer_d = 8'h00;
            end
            WAIT: begin
                if (match) begin
                    state_d     = DONE;
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = alu_res;
                    rsp_err_d   = 1'b0;
                end else if (timer_q == TMO_LAST) begin
                    state_d     = DONE;
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = 32'h0;
                    rsp_err_d   = 1'b1;
                    tmo_clr_d   = 1'b1;
                end else begin
                    timer_d = timer_q + 8'h01;
                end
            end
            DONE: begin
                if (rsp_ready) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control strobes are forced low while reset is held.
    always_comb begin
        req_ready = 1'b0;
        alu_en    = 1'b0;
        alu_clr   = 1'b0;
        if (!rst) begin
            req_ready = (state_q == IDLE);
            alu_en    = (state_q == WAIT) && !match;
            alu_clr   = (state_q == ISSUE) || tmo_clr_q;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;
    assign alu_op    = alu_op_q;
    assign alu_key   = alu_key_q;
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;

endmodule

// File: tb/tb_alu32_dispatch.sv
// Randomized bench for alu32_dispatch with a behavioural ALU and response reference model.
module tb_alu32_dispatch;

    localparam int TIMEOUT = 15;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [7:0]  req_op;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic        alu_en;
    logic        alu_clr;
    logic [7:0]  alu_op;
    logic [7:0]  alu_key;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [31:0] alu_res;
    logic [7:0]  alu_key_ret;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_key  = 1;
    bit mute     = 1'b0;

    alu32_dispatch #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .alu_en(alu_en), .alu_clr(alu_clr), .alu_op(alu_op), .alu_key(alu_key),
        .alu_a(alu_a), .alu_b(alu_b), .alu_res(alu_res), .alu_key_ret(alu_key_ret)
    );

    always #5 clk = ~clk;

    // Behavioural ALU: ADD/SUB finish on the first enabled edge, MUL on the fourth.
    int m_cnt;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_res <= 32'h0; alu_key_ret <= 8'h00; m_cnt <= 0;
        end else if (alu_clr) begin
            alu_key_ret <= 8'h00; m_cnt <= 0;
        end else if (alu_en) begin
            if (m_cnt + 1 >= ((alu_op == 8'h03) ? 4 : 1)) begin
                m_cnt <= 0;
                if (!mute) begin
                    alu_key_ret <= alu_key;
                    case (alu_op)
                        8'h01:   alu_res <= alu_a + alu_b;
                        8'h02:   alu_res <= alu_a - alu_b;
                        default: alu_res <= alu_a * alu_b;
                    endcase
                end
            end else begin
                m_cnt       <= m_cnt + 1;
                alu_key_ret <= 8'h00;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] got);
        logic        valid_op;
        logic [31:0] exp_d;
        logic        exp_e;
        int n, en_cnt, clr_cnt, exp_lat, exp_en, exp_clr;
        valid_op = (op >= 8'h01) && (op <= 8'h03);
        en_cnt = 0; clr_cnt = 0;
        if (!valid_op) begin
            exp_d = 32'h0; exp_e = 1'b1; exp_lat = 1; exp_en = 0; exp_clr = 0;
        end else if (mute) begin
            exp_d = 32'h0; exp_e = 1'b1; exp_lat = TIMEOUT + 2; exp_en = TIMEOUT; exp_clr = 2;
        end else begin
            exp_e = 1'b0; exp_clr = 1;
            if (op == 8'h01)      exp_d = a + b;
            else if (op == 8'h02) exp_d = a - b;
            else                  exp_d = 32'((64'(a) * 64'(b)) % 64'h1_0000_0000);
            exp_lat = (op == 8'h03) ? 7 : 4;
            exp_en  = (op == 8'h03) ? 4 : 1;
        end
        req_valid = 1'b1; req_op = op; req_a = a; req_b = b; rsp_ready = 1'b1;
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk); n++;
        end
        if (n >= 50) check("req_ready_timeout", 32'(req_ready), 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        req_op = $urandom; req_a = $urandom; req_b = $urandom;
        check("ready_after_accept", 32'(req_ready), 32'd0);
        if (valid_op) begin
            check("alu_key", 32'(alu_key), 32'(exp_key));
            exp_key = (exp_key == 255) ? 1 : exp_key + 1;
        end
        n = 0;
        while (!rsp_valid && n < 100) begin
            if (alu_en)  en_cnt++;
            if (alu_clr) clr_cnt++;
            @(negedge clk); n++;
        end
        if (alu_clr) clr_cnt++;
        check("latency", 32'(n + 1), 32'(exp_lat));
        check("en_cycles", 32'(en_cnt), 32'(exp_en));
        check("clr_cycles", 32'(clr_cnt), 32'(exp_clr));
        check("rsp_data", rsp_data, exp_d);
        check("rsp_err", 32'(rsp_err), 32'(exp_e));
        got = rsp_data;
        @(negedge clk);
        check("rsp_consumed", 32'(rsp_valid), 32'd0);
    endtask

    task automatic check_reset_outputs();
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_data", rsp_data, 32'd0);
        check("rst_rsp_err", 32'(rsp_err), 32'd0);
        check("rst_alu_en", 32'(alu_en), 32'd0);
        check("rst_alu_clr", 32'(alu_clr), 32'd0);
        check("rst_alu_op", 32'(alu_op), 32'd0);
        check("rst_alu_key", 32'(alu_key), 32'd0);
        check("rst_alu_a", alu_a, 32'd0);
        check("rst_alu_b", alu_b, 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_reset_outputs();
        @(negedge clk);
        rst = 1'b0;
        exp_key = 1;
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] got;
        logic [31:0] held;
        logic [7:0]  op;
        int n;
        rst = 1'b1; req_valid = 1'b0; req_op = 8'h00; req_a = 32'h0; req_b = 32'h0;
        rsp_ready = 1'b1;
        repeat (2) @(negedge clk);
        do_reset();

        run_op(8'h01, 32'h5, 32'h7, got);
        check("add_const", got, 32'h0000000C);
        do_reset();
        run_op(8'h02, 32'h3, 32'h5, got);
        check("sub_const", got, 32'hFFFFFFFE);
        run_op(8'h03, 32'h00012345, 32'h10, got);
        check("mul_const", got, 32'h00123450);
        run_op(8'h07, 32'h1234, 32'h5678, got);

        mute = 1'b1;
        run_op(8'h01, 32'h1, 32'h2, got);
        mute = 1'b0;
        run_op(8'h01, 32'h10, 32'h20, got);
        check("after_timeout", got, 32'h30);

        for (int i = 0; i < 60; i++) begin
            n = $urandom_range(0, 3);
            op = (n == 3) ? 8'($urandom_range(4, 255)) : 8'(n + 1);
            run_op(op, $urandom, $urandom, got);
        end

        do_reset();
        for (int i = 0; i < 256; i++) run_op(8'h01, $urandom, $urandom, got);
        check("key_wrap_next", 32'(exp_key), 32'd2);
        run_op(8'h01, 32'hFFFFFFFF, 32'h1, got);

        // Backpressure: hold the MUL response for 10 cycles.
        req_valid = 1'b1; req_op = 8'h03; req_a = 32'h1000; req_b = 32'h3; rsp_ready = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        exp_key = (exp_key == 255) ? 1 : exp_key + 1;
        n = 0;
        while (!rsp_valid && n < 100) begin
            @(negedge clk); n++;
        end
        check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
        held = rsp_data;
        check("bp_data", held, 32'h3000);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_hold_valid", 32'(rsp_valid), 32'd1);
            check("bp_hold_data", rsp_data, 32'h3000);
            check("bp_req_ready", 32'(req_ready), 32'd0);
            check("bp_alu_en", 32'(alu_en), 32'd0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        check("bp_released", 32'(rsp_valid), 32'd0);

        // Reset in the middle of a MUL.
        req_valid = 1'b1; req_op = 8'h03; req_a = 32'h7; req_b = 32'h9;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("mid_mul_en", 32'(alu_en), 32'd1);
        rst = 1'b1;
        #1;
        check_reset_outputs();
        @(negedge clk);
        rst = 1'b0;
        exp_key = 1;
        repeat (3) begin
            @(negedge clk);
            check("no_rsp_after_rst", 32'(rsp_valid), 32'd0);
        end
        run_op(8'h01, 32'h100, 32'h23, got);
        check("post_rst_result", got, 32'h123);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
